urng_taus_pair: RTL and testbench



---
 rtl/urng_taus_pair_pkg.sv | 24 ++
 rtl/urng_taus_pair_core.sv | 59 +++++
 rtl/urng_taus_pair.sv | 110 +++++++++++
 tb/tb_urng_taus_pair.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urng_taus_pair_pkg.sv
// Shared constants and types for the taus88 pair source.
// Seed expansion keys, sanitisation floors, FSM states.
package urng_taus_pair_pkg;

  localparam logic [31:0] TAUS_GOLD_2 = 32'h9E37_79B9;
  localparam logic [31:0] TAUS_GOLD_3 = 32'h7F4A_7C15;

  localparam logic [31:0] TAUS_MIN_1 = 32'd2;
  localparam logic [31:0] TAUS_MIN_2 = 32'd8;
  localparam logic [31:0] TAUS_MIN_3 = 32'd16;

  typedef enum logic {
    WARMUP,
    RUN
  } state_t;

  function automatic logic [31:0] taus_floor(
    input logic [31:0] v,
    input logic [31:0] lo
  );
    return (v < lo) ? lo : v;
  endfunction

endpackage

// File: rtl/urng_taus_pair_core.sv
// One taus88 generator: seed expansion, three state words, step.
// word is the xor of the stepped state, valid in the same cycle.
module taus88_core
  import urng_taus_pair_pkg::*;
#(
  parameter logic [31:0] RESET_SEED = 32'h1234_5678
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] word
);

  logic [31:0] s1_q, s2_q, s3_q;
  logic [31:0] s1_n, s2_n, s3_n;
  logic [31:0] ld1, ld2, ld3;
  logic [31:0] rs1, rs2, rs3;

  // expand and sanitise both the runtime and the reset seed
  always_comb begin
    ld1 = taus_floor(seed, TAUS_MIN_1);
    ld2 = taus_floor(seed ^ TAUS_GOLD_2, TAUS_MIN_2);
    ld3 = taus_floor(seed ^ TAUS_GOLD_3, TAUS_MIN_3);
    rs1 = taus_floor(RESET_SEED, TAUS_MIN_1);
    rs2 = taus_floor(RESET_SEED ^ TAUS_GOLD_2, TAUS_MIN_2);
    rs3 = taus_floor(RESET_SEED ^ TAUS_GOLD_3, TAUS_MIN_3);
  end

  // taus88 step of the three components
  always_comb begin
    s1_n = ((s1_q & ~32'd1) << 12)
         ^ (((s1_q << 13) ^ s1_q) >> 19);
    s2_n = ((s2_q & ~32'd7) << 4)
         ^ (((s2_q << 2) ^ s2_q) >> 25);
    s3_n = ((s3_q & ~32'd15) << 17)
         ^ (((s3_q << 3) ^ s3_q) >> 11);
    word = s1_n ^ s2_n ^ s3_n;
  end

  // state registers: reset seed, runtime seed, or step
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= rs1;
      s2_q <= rs2;
      s3_q <= rs3;
    end else if (load) begin
      s1_q <= ld1;
      s2_q <= ld2;
      s3_q <= ld3;
    end else if (step) begin
      s1_q <= s1_n;
      s2_q <= s2_n;
      s3_q <= s3_n;
    end
  end

endmodule

// File: rtl/urng_taus_pair.sv
// Paired taus88 uniform source with warm-up and valid/ready output.
// Generators only advance when a word is consumed, so none is lost.
module urng_taus_pair
  import urng_taus_pair_pkg::*;
#(
  parameter int          WARMUP_CYCLES  = 16,
  parameter logic [31:0] DEFAULT_SEED_A = 32'h1234_5678,
  parameter logic [31:0] DEFAULT_SEED_B = 32'h8765_4321
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_load,
  input  logic [31:0] seed_a,
  input  logic [31:0] seed_b,
  input  logic        urng_ready,
  output logic        urng_valid,
  output logic [31:0] urng_seed1,
  output logic [31:0] urng_seed2,
  output logic        warm
);

  localparam logic [7:0] WARM_INIT = 8'(WARMUP_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] out1_q, out1_d;
  logic [31:0] out2_q, out2_d;
  logic [31:0] word_a, word_b;
  logic        open;
  logic        step;

  taus88_core #(
    .RESET_SEED(DEFAULT_SEED_A)
  ) u_core_a (
    .clk  (clk),
    .reset(reset),
    .load (seed_load),
    .seed (seed_a),
    .step (step),
    .word (word_a)
  );

  taus88_core #(
    .RESET_SEED(DEFAULT_SEED_B)
  ) u_core_b (
    .clk  (clk),
    .reset(reset),
    .load (seed_load),
    .seed (seed_b),
    .step (step),
    .word (word_b)
  );

  // next state, counter, output register and generator step
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    open    = !valid_q || urng_ready;
    step    = 1'b0;
    if (seed_load) begin
      state_d = WARMUP;
      cnt_d   = WARM_INIT;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        WARMUP: begin
          step  = 1'b1;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = RUN;
        end
        RUN: begin
          if (open) begin
            step    = 1'b1;
            valid_d = 1'b1;
            out1_d  = word_a;
            out2_d  = word_b;
          end
        end
        default: state_d = WARMUP;
      endcase
    end
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WARMUP;
      cnt_q   <= WARM_INIT;
      valid_q <= 1'b0;
      out1_q  <= '0;
      out2_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
    end
  end

  assign urng_valid = valid_q;
  assign urng_seed1 = out1_q;
  assign urng_seed2 = out2_q;
  assign warm       = (state_q == WARMUP);

endmodule

// File: tb/tb_urng_taus_pair.sv
// Directed bench for urng_taus_pair: seed table, latency, stall,
// reseed, reset priority and back-pressure repeatability.
module tb_urng_taus_pair;

  localparam logic [31:0] DEF_A = 32'h1234_5678;
  localparam logic [31:0] DEF_B = 32'h8765_4321;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        seed_load = 1'b0;
  logic [31:0] seed_a = '0;
  logic [31:0] seed_b = '0;
  logic        urng_ready = 1'b1;
  logic        urng_valid;
  logic [31:0] urng_seed1;
  logic [31:0] urng_seed2;
  logic        warm;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  urng_taus_pair dut (
    .clk       (clk),
    .reset     (reset),
    .seed_load (seed_load),
    .seed_a    (seed_a),
    .seed_b    (seed_b),
    .urng_ready(urng_ready),
    .urng_valid(urng_valid),
    .urng_seed1(urng_seed1),
    .urng_seed2(urng_seed2),
    .warm      (warm)
  );

  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] s3;
  } ts_t;

  typedef struct {
    logic [31:0] seed;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] s3;
    logic [31:0] s1_step;
  } vec_t;

  ts_t ma, mb;

  function automatic ts_t m_seed(input logic [31:0] s);
    ts_t t;
    t.s1 = s;
    t.s2 = s ^ 32'h9E37_79B9;
    t.s3 = s ^ 32'h7F4A_7C15;
    if (t.s1 < 2)  t.s1 = 2;
    if (t.s2 < 8)  t.s2 = 8;
    if (t.s3 < 16) t.s3 = 16;
    return t;
  endfunction

  function automatic ts_t m_step(input ts_t t);
    ts_t n;
    n.s1 = ((t.s1 & 32'hFFFF_FFFE) << 12)
         ^ (((t.s1 << 13) ^ t.s1) >> 19);
    n.s2 = ((t.s2 & 32'hFFFF_FFF8) << 4)
         ^ (((t.s2 << 2) ^ t.s2) >> 25);
    n.s3 = ((t.s3 & 32'hFFFF_FFF0) << 17)
         ^ (((t.s3 << 3) ^ t.s3) >> 11);
    return n;
  endfunction

  task automatic m_init(input logic [31:0] a, input logic [31:0] b);
    ma = m_seed(a);
    mb = m_seed(b);
    repeat (16) begin
      ma = m_step(ma);
      mb = m_step(mb);
    end
  endtask

  task automatic m_next(output logic [63:0] p);
    ma = m_step(ma);
    mb = m_step(mb);
    p = {ma.s1 ^ ma.s2 ^ ma.s3, mb.s1 ^ mb.s2 ^ mb.s3};
  endtask

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_seeds(input logic [31:0] a, input logic [31:0] b);
    seed_a = a;
    seed_b = b;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  // edge number (load/reset edge = 1) at which valid is first seen
  task automatic wait_valid(output int edges);
    edges = 1;
    while (!urng_valid && edges < 60) begin
      tick();
      edges++;
    end
  endtask

  task automatic chk_stream(input string nm, input int n);
    logic [63:0] p;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      m_next(p);
      chk(nm, {urng_seed1, urng_seed2}, p);
    end
  endtask

  task automatic collect(output logic [63:0] q[$]);
    int cyc = 0;
    q = {};
    load_seeds(32'hDEAD_BEEF, 32'hCAFE_F00D);
    while (q.size() < 50 && cyc < 3000) begin
      urng_ready = 1'($urandom_range(0, 1));
      #1;
      if (urng_valid && urng_ready)
        q.push_back({urng_seed1, urng_seed2});
      tick();
      cyc++;
    end
    urng_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tab[6];
    int          edges;
    int          warm_cnt;
    logic [63:0] held, p;
    logic [63:0] q1[$], q2[$];

    tab[0] = '{32'h0000_0000, 32'h2, 32'h9E37_79B9,
               32'h7F4A_7C15, 32'h0000_2000};
    tab[1] = '{32'h0000_0001, 32'h2, 32'h9E37_79B8,
               32'h7F4A_7C14, 32'h0000_2000};
    tab[2] = '{32'h9E37_79B9, 32'h9E37_79B9, 32'h8,
               32'hE17D_05AC, 32'h779B_8E20};
    tab[3] = '{32'h7F4A_7C15, 32'h7F4A_7C15, 32'hE17D_05AC,
               32'h10, 32'hA7C1_4619};
    tab[4] = '{32'h9E37_79BE, 32'h9E37_79BE, 32'h8,
               32'hE17D_05AB, 32'h779B_EE20};
    tab[5] = '{32'h7F4A_7C1A, 32'h7F4A_7C1A, 32'hE17D_05A3,
               32'h10, 32'hA7C1_A619};

    // reset release, latency, warm length, long stream
    reset = 1'b1;
    urng_ready = 1'b1;
    tick();
    chk("rst_valid", 64'(urng_valid), 64'd0);
    chk("rst_warm", 64'(warm), 64'd1);
    chk("rst_out", {urng_seed1, urng_seed2}, 64'd0);
    reset = 1'b0;
    warm_cnt = 1;
    edges = 1;
    while (!urng_valid && edges < 60) begin
      tick();
      edges++;
      if (warm) warm_cnt++;
    end
    chk("rst_latency", 64'(edges), 64'd18);
    chk("warm_len", 64'(warm_cnt), 64'd16);
    m_init(DEF_A, DEF_B);
    chk_stream("stream", 1000);

    // seed table: expansion, sanitisation, first step
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      load_seeds(tab[i].seed, tab[i].seed);
      seed_load = 1'b1;
      chk("tab_s1", 64'(dut.u_core_a.s1_q), 64'(tab[i].s1));
      chk("tab_s2", 64'(dut.u_core_a.s2_q), 64'(tab[i].s2));
      chk("tab_s3", 64'(dut.u_core_a.s3_q), 64'(tab[i].s3));
      chk("tab_b_s1", 64'(dut.u_core_b.s1_q), 64'(tab[i].s1));
      seed_load = 1'b0;
      tick();
      chk("tab_step", 64'(dut.u_core_a.s1_q),
          64'(tab[i].s1_step));
    end

    // stall for 10 cycles in RUN
    load_seeds(32'hDEAD_BEEF, 32'hCAFE_F00D);
    wait_valid(edges);
    chk("seed_latency", 64'(edges), 64'd18);
    m_init(32'hDEAD_BEEF, 32'hCAFE_F00D);
    chk_stream("pre_stall", 5);
    held = {urng_seed1, urng_seed2};
    urng_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_hold", {urng_seed1, urng_seed2}, held);
      chk("stall_valid", 64'(urng_valid), 64'd1);
    end
    urng_ready = 1'b1;
    tick();
    chk_stream("post_stall", 3);

    // reseed while a pair is pending
    urng_ready = 1'b0;
    seed_a = 32'h0BAD_F00D;
    seed_b = 32'h1357_9BDF;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("reseed_valid", 64'(urng_valid), 64'd0);
    chk("reseed_warm", 64'(warm), 64'd1);
    urng_ready = 1'b1;
    wait_valid(edges);
    chk("reseed_latency", 64'(edges), 64'd18);
    m_init(32'h0BAD_F00D, 32'h1357_9BDF);
    chk_stream("reseed_stream", 20);

    // held seed_load restarts warm-up every cycle
    seed_a = 32'h1111_2222;
    seed_b = 32'h3333_4444;
    seed_load = 1'b1;
    repeat (5) tick();
    seed_a = 32'h5555_6666;
    tick();
    seed_load = 1'b0;
    wait_valid(edges);
    chk("hold_latency", 64'(edges), 64'd18);
    m_init(32'h5555_6666, 32'h3333_4444);
    chk_stream("hold_stream", 5);

    // reset with seed_load mid warm-up
    load_seeds(32'hAAAA_5555, 32'h5555_AAAA);
    repeat (9) tick();
    chk("mid_cnt", 64'(dut.cnt_q), 64'd7);
    reset = 1'b1;
    seed_load = 1'b1;
    tick();
    reset = 1'b0;
    seed_load = 1'b0;
    chk("rst_pri_cnt", 64'(dut.cnt_q), 64'd16);
    chk("rst_pri_out", {urng_seed1, urng_seed2}, 64'd0);
    wait_valid(edges);
    chk("rst_pri_latency", 64'(edges), 64'd18);
    m_init(DEF_A, DEF_B);
    chk_stream("rst_pri_stream", 10);

    // random back-pressure, two identical-seed runs
    collect(q1);
    collect(q2);
    chk("bp_size1", 64'(q1.size()), 64'd50);
    chk("bp_size2", 64'(q2.size()), 64'd50);
    m_init(32'hDEAD_BEEF, 32'hCAFE_F00D);
    for (int i = 0; i < q1.size() && i < q2.size(); i++) begin
      m_next(p);
      chk("bp_model", q1[i], p);
      chk("bp_repeat", q2[i], q1[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
